cv32e40s_pma_gate: RTL and testbench



---
 rtl/cv32e40s_pkg.sv | 28 ++
 rtl/cv32e40s_outstanding_cnt.sv | 49 ++++
 rtl/cv32e40s_pma_gate.sv | 151 +++++++++++++++
 tb/tb_cv32e40s_pma_gate.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40s_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40s_pkg
// Shared types and constants for the PMA transaction gate.
//   pma_gate_state_e  : gate FSM states
//   MEMTYPE_*_BIT     : bit positions inside the 2-bit OBI memtype attribute
//   pma_memtype()     : packs the PMA verdict into the memtype attribute
// ---------------------------------------------------------------------------
package cv32e40s_pkg;

    typedef enum logic [1:0] {
        PG_IDLE     = 2'd0,
        PG_ERR_WAIT = 2'd1,
        PG_ERR_RESP = 2'd2
    } pma_gate_state_e;

    localparam int unsigned MEMTYPE_BUFFERABLE_BIT = 0;
    localparam int unsigned MEMTYPE_CACHEABLE_BIT  = 1;

    function automatic logic [1:0] pma_memtype(input logic cacheable,
                                               input logic bufferable);
        logic [1:0] memtype;
        memtype                         = 2'b00;
        memtype[MEMTYPE_CACHEABLE_BIT]  = cacheable;
        memtype[MEMTYPE_BUFFERABLE_BIT] = bufferable;
        return memtype;
    endfunction

endpackage

// File: rtl/cv32e40s_outstanding_cnt.sv
// ---------------------------------------------------------------------------
// cv32e40s_outstanding_cnt
// Saturating up/down counter of outstanding bus transactions.
//   clk, rst_n : clock, asynchronous active-low reset
//   inc_i      : a transaction was issued this cycle
//   dec_i      : a transaction completed this cycle
//   cnt_o      : current count
//   full_o     : count equals MAX_CNT
//   empty_o    : count is zero
// ---------------------------------------------------------------------------
module cv32e40s_outstanding_cnt #(
    parameter int unsigned MAX_CNT = 2,
    parameter int unsigned CNT_W   = $clog2(MAX_CNT + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign full_o  = (cnt_q == CNT_W'(MAX_CNT));
    assign empty_o = (cnt_q == '0);
    assign cnt_o   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && !dec_i) begin
            if (!full_o) cnt_d = cnt_q + CNT_W'(1);
        end else if (dec_i && !inc_i) begin
            // A completion with nothing outstanding is ignored (no underflow).
            if (!empty_o) cnt_d = cnt_q - CNT_W'(1);
        end else if (inc_i && dec_i && empty_o) begin
            // Stray completion coinciding with an issue: only the issue counts.
            cnt_d = CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/cv32e40s_pma_gate.sv
// ---------------------------------------------------------------------------
// cv32e40s_pma_gate
// Gate between a core requester and the OBI bus. Requests passing the PMA
// check go straight to the bus with memtype attached; failing requests are
// accepted but never issued, and are answered with a local PMA error once all
// earlier bus transactions have responded, keeping responses in order.
//   core_trans_* : core request (valid/ready, addr, we, instr, misaligned)
//   core_resp_*  : response to core (valid, rdata, err, pma_err)
//   pma_*_o/_i   : drive the external PMA checker / its same-cycle verdict
//   bus_trans_*  : bus request (valid/ready, addr, we, memtype)
//   bus_resp_*   : bus response (valid, rdata, err)
// ---------------------------------------------------------------------------
module cv32e40s_pma_gate
    import cv32e40s_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_trans_valid_i,
    output logic        core_trans_ready_o,
    input  logic [31:0] core_trans_addr_i,
    input  logic        core_trans_we_i,
    input  logic        core_trans_instr_i,
    input  logic        core_trans_misaligned_i,
    output logic        core_resp_valid_o,
    output logic [31:0] core_resp_rdata_o,
    output logic        core_resp_err_o,
    output logic        core_resp_pma_err_o,
    output logic [31:0] pma_addr_o,
    output logic        pma_instr_fetch_o,
    output logic        pma_misaligned_o,
    output logic        pma_load_o,
    input  logic        pma_err_i,
    input  logic        pma_bufferable_i,
    input  logic        pma_cacheable_i,
    output logic        bus_trans_valid_o,
    input  logic        bus_trans_ready_i,
    output logic [31:0] bus_trans_addr_o,
    output logic        bus_trans_we_o,
    output logic [1:0]  bus_trans_memtype_o,
    input  logic        bus_resp_valid_i,
    input  logic [31:0] bus_resp_rdata_i,
    input  logic        bus_resp_err_i
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    pma_gate_state_e  state_q;
    pma_gate_state_e  state_d;
    logic [CNT_W-1:0] cnt;
    logic             cnt_full;
    logic             cnt_empty;
    logic             err_drained;
    logic             trans_ready;
    logic             bus_valid;
    logic             err_resp;
    logic             bus_hs;

    // PMA checker sees the raw core request.
    assign pma_addr_o        = core_trans_addr_i;
    assign pma_instr_fetch_o = core_trans_instr_i;
    assign pma_misaligned_o  = core_trans_misaligned_i;
    assign pma_load_o        = !core_trans_we_i && !core_trans_instr_i;

    assign bus_trans_addr_o    = core_trans_addr_i;
    assign bus_trans_we_o      = core_trans_we_i;
    assign bus_trans_memtype_o = pma_memtype(pma_cacheable_i, pma_bufferable_i);

    // All earlier bus transactions have responded by the end of this cycle.
    assign err_drained = cnt_empty || ((cnt == CNT_W'(1)) && bus_resp_valid_i);

    // Handshake uses the ungated valid so reset never feeds flop data paths.
    assign bus_hs = bus_valid && bus_trans_ready_i;

    cv32e40s_outstanding_cnt #(
        .MAX_CNT (MAX_OUTSTANDING),
        .CNT_W   (CNT_W)
    ) u_outstanding_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (bus_hs),
        .dec_i   (bus_resp_valid_i),
        .cnt_o   (cnt),
        .full_o  (cnt_full),
        .empty_o (cnt_empty)
    );

    always_comb begin
        state_d     = state_q;
        trans_ready = 1'b0;
        bus_valid   = 1'b0;
        err_resp    = 1'b0;
        case (state_q)
            PG_IDLE: begin
                if (core_trans_valid_i && pma_err_i) begin
                    // Blocked request is absorbed; its response is owed later.
                    trans_ready = 1'b1;
                    state_d     = err_drained ? PG_ERR_RESP : PG_ERR_WAIT;
                end else begin
                    bus_valid   = core_trans_valid_i && !cnt_full;
                    trans_ready = bus_trans_ready_i && !cnt_full;
                end
            end
            PG_ERR_WAIT: begin
                if (err_drained) state_d = PG_ERR_RESP;
            end
            PG_ERR_RESP: begin
                err_resp = 1'b1;
                state_d  = PG_IDLE;
            end
            default: state_d = PG_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= PG_IDLE;
        else        state_q <= state_d;
    end

    // Handshake and response strobes are forced low while reset is held.
    assign core_trans_ready_o  = rst_n && trans_ready;
    assign bus_trans_valid_o   = rst_n && bus_valid;
    assign core_resp_valid_o   = rst_n && (err_resp || bus_resp_valid_i);
    assign core_resp_err_o     = rst_n && !err_resp && bus_resp_err_i;
    assign core_resp_pma_err_o = rst_n && err_resp;
    assign core_resp_rdata_o   = err_resp ? 32'h0 : bus_resp_rdata_i;

`ifndef SYNTHESIS
    a_no_bus_on_err: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == PG_IDLE && core_trans_valid_i && pma_err_i) |-> !bus_trans_valid_o);

    a_cnt_bound: assert property (@(posedge clk) disable iff (!rst_n)
        cnt <= CNT_W'(MAX_OUTSTANDING));

    a_err_resp_single: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == PG_ERR_RESP) |=> (state_q == PG_IDLE));

    a_err_wait_blocks: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != PG_IDLE) |-> (!core_trans_ready_o && !bus_trans_valid_o));

    a_core_valid_held: assert property (@(posedge clk) disable iff (!rst_n)
        (core_trans_valid_i && !core_trans_ready_o) |=> core_trans_valid_i);

    // Protocol violation by the bus; flagged but the gate recovers on its own.
    a_resp_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
        bus_resp_valid_i |-> !cnt_empty)
        else $warning("bus response received with no transaction outstanding");
`endif

endmodule

// File: tb/tb_cv32e40s_pma_gate.sv
// ---------------------------------------------------------------------------
// tb_cv32e40s_pma_gate
// Directed scenarios followed by a randomized run checked against an
// in-order response queue model of the gate.
// ---------------------------------------------------------------------------
module tb_cv32e40s_pma_gate;

    localparam int unsigned MAX = 2;

    logic        clk;
    logic        rst_n;
    logic        core_trans_valid_i;
    logic        core_trans_ready_o;
    logic [31:0] core_trans_addr_i;
    logic        core_trans_we_i;
    logic        core_trans_instr_i;
    logic        core_trans_misaligned_i;
    logic        core_resp_valid_o;
    logic [31:0] core_resp_rdata_o;
    logic        core_resp_err_o;
    logic        core_resp_pma_err_o;
    logic [31:0] pma_addr_o;
    logic        pma_instr_fetch_o;
    logic        pma_misaligned_o;
    logic        pma_load_o;
    logic        pma_err_i;
    logic        pma_bufferable_i;
    logic        pma_cacheable_i;
    logic        bus_trans_valid_o;
    logic        bus_trans_ready_i;
    logic [31:0] bus_trans_addr_o;
    logic        bus_trans_we_o;
    logic [1:0]  bus_trans_memtype_o;
    logic        bus_resp_valid_i;
    logic [31:0] bus_resp_rdata_i;
    logic        bus_resp_err_i;

    int n_checks = 0;
    int n_fail   = 0;

    cv32e40s_pma_gate #(.MAX_OUTSTANDING(MAX)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .core_trans_valid_i      (core_trans_valid_i),
        .core_trans_ready_o      (core_trans_ready_o),
        .core_trans_addr_i       (core_trans_addr_i),
        .core_trans_we_i         (core_trans_we_i),
        .core_trans_instr_i      (core_trans_instr_i),
        .core_trans_misaligned_i (core_trans_misaligned_i),
        .core_resp_valid_o       (core_resp_valid_o),
        .core_resp_rdata_o       (core_resp_rdata_o),
        .core_resp_err_o         (core_resp_err_o),
        .core_resp_pma_err_o     (core_resp_pma_err_o),
        .pma_addr_o              (pma_addr_o),
        .pma_instr_fetch_o       (pma_instr_fetch_o),
        .pma_misaligned_o        (pma_misaligned_o),
        .pma_load_o              (pma_load_o),
        .pma_err_i               (pma_err_i),
        .pma_bufferable_i        (pma_bufferable_i),
        .pma_cacheable_i         (pma_cacheable_i),
        .bus_trans_valid_o       (bus_trans_valid_o),
        .bus_trans_ready_i       (bus_trans_ready_i),
        .bus_trans_addr_o        (bus_trans_addr_o),
        .bus_trans_we_o          (bus_trans_we_o),
        .bus_trans_memtype_o     (bus_trans_memtype_o),
        .bus_resp_valid_i        (bus_resp_valid_i),
        .bus_resp_rdata_i        (bus_resp_rdata_i),
        .bus_resp_err_i          (bus_resp_err_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_in();
        core_trans_valid_i      = 1'b0;
        core_trans_addr_i       = 32'h0;
        core_trans_we_i         = 1'b0;
        core_trans_instr_i      = 1'b0;
        core_trans_misaligned_i = 1'b0;
        pma_err_i               = 1'b0;
        pma_bufferable_i        = 1'b0;
        pma_cacheable_i         = 1'b0;
        bus_trans_ready_i       = 1'b0;
        bus_resp_valid_i        = 1'b0;
        bus_resp_rdata_i        = 32'h0;
        bus_resp_err_i          = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] a);
        idle_in();
        core_trans_valid_i = 1'b1;
        core_trans_addr_i  = a;
        bus_trans_ready_i  = 1'b1;
    endtask

    task automatic test_reset();
        idle_in();
        rst_n              = 1'b0;
        core_trans_valid_i = 1'b1;
        bus_trans_ready_i  = 1'b1;
        bus_resp_valid_i   = 1'b1;
        bus_resp_err_i     = 1'b1;
        #12;
        n_checks++; if (core_trans_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", core_trans_ready_o); end
        n_checks++; if (bus_trans_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_bus_valid: got %b want 0", bus_trans_valid_o); end
        n_checks++; if (core_resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b want 0", core_resp_valid_o); end
        n_checks++; if (core_resp_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b want 0", core_resp_err_o); end
        n_checks++; if (core_resp_pma_err_o !== 1'b0) begin n_fail++; $display("FAIL reset_pma_err: got %b want 0", core_resp_pma_err_o); end
        idle_in();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        bus_trans_ready_i = 1'b1;
        @(negedge clk);
        n_checks++; if (core_trans_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_idle_ready: got %b want 1", core_trans_ready_o); end
        next_cycle();
        $display("test_reset done");
    endtask

    task automatic test_pass_load();
        load(32'h0000_1000);
        pma_cacheable_i = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_trans_valid_o !== 1'b1) begin n_fail++; $display("FAIL pass_bus_valid: got %b want 1", bus_trans_valid_o); end
        n_checks++; if (core_trans_ready_o !== 1'b1) begin n_fail++; $display("FAIL pass_ready: got %b want 1", core_trans_ready_o); end
        n_checks++; if (bus_trans_addr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL pass_addr: got %h want 00001000", bus_trans_addr_o); end
        n_checks++; if (bus_trans_memtype_o !== 2'b10) begin n_fail++; $display("FAIL pass_memtype: got %b want 10", bus_trans_memtype_o); end
        n_checks++; if (pma_load_o !== 1'b1) begin n_fail++; $display("FAIL pass_pma_load: got %b want 1", pma_load_o); end
        n_checks++; if (pma_addr_o !== 32'h0000_1000) begin n_fail++; $display("FAIL pass_pma_addr: got %h want 00001000", pma_addr_o); end
        next_cycle();
        idle_in();
        bus_resp_valid_i = 1'b1;
        bus_resp_rdata_i = 32'hDEAD_BEEF;
        @(negedge clk);
        n_checks++; if (core_resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL pass_resp_valid: got %b want 1", core_resp_valid_o); end
        n_checks++; if (core_resp_rdata_o !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL pass_rdata: got %h want deadbeef", core_resp_rdata_o); end
        n_checks++; if (core_resp_pma_err_o !== 1'b0) begin n_fail++; $display("FAIL pass_pma_err: got %b want 0", core_resp_pma_err_o); end
        next_cycle();
        idle_in();
        $display("test_pass_load done");
    endtask

    task automatic test_err_fetch();
        load(32'h1A00_0000);
        core_trans_instr_i = 1'b1;
        pma_err_i          = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_trans_valid_o !== 1'b0) begin n_fail++; $display("FAIL errf_bus_valid: got %b want 0", bus_trans_valid_o); end
        n_checks++; if (core_trans_ready_o !== 1'b1) begin n_fail++; $display("FAIL errf_ready: got %b want 1", core_trans_ready_o); end
        n_checks++; if (pma_instr_fetch_o !== 1'b1) begin n_fail++; $display("FAIL errf_pma_fetch: got %b want 1", pma_instr_fetch_o); end
        n_checks++; if (core_resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL errf_early_resp: got %b want 0", core_resp_valid_o); end
        next_cycle();
        idle_in();
        bus_trans_ready_i = 1'b1;
        @(negedge clk);
        n_checks++; if (core_resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL errf_resp_valid: got %b want 1", core_resp_valid_o); end
        n_checks++; if (core_resp_pma_err_o !== 1'b1) begin n_fail++; $display("FAIL errf_pma_err: got %b want 1", core_resp_pma_err_o); end
        n_checks++; if (core_resp_rdata_o !== 32'h0) begin n_fail++; $display("FAIL errf_rdata: got %h want 0", core_resp_rdata_o); end
        n_checks++; if (core_trans_ready_o !== 1'b0) begin n_fail++; $display("FAIL errf_resp_ready: got %b want 0", core_trans_ready_o); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (core_resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL errf_single_resp: got %b want 0", core_resp_valid_o); end
        next_cycle();
        idle_in();
        $display("test_err_fetch done");
    endtask

    task automatic test_err_after_outstanding();
        load(32'h2000);
        pma_bufferable_i = 1'b1;
        @(negedge clk);
        n_checks++; if (bus_trans_memtype_o !== 2'b01) begin n_fail++; $display("FAIL erro_memtype: got %b want 01", bus_trans_memtype_o); end
        next_cycle();
        load(32'h2004);
        @(negedge clk);
        n_checks++; if (core_trans_ready_o !== 1'b1) begin n_fail++; $display("FAIL erro_ld2_ready: got %b want 1", core_trans_ready_o); end
        next_cycle();
        load(32'h3000);
        core_trans_we_i = 1'b1;
        pma_err_i       = 1'b1;
        @(negedge clk);
        n_checks++; if (core_trans_ready_o !== 1'b1) begin n_fail++; $display("FAIL erro_st_ready: got %b want 1", core_trans_ready_o); end
        n_checks++; if (bus_trans_valid_o !== 1'b0) begin n_fail++; $display("FAIL erro_st_bus: got %b want 0", bus_trans_valid_o); end
        next_cycle();
        load(32'h4000);
        bus_resp_valid_i = 1'b1;
        bus_resp_rdata_i = 32'h1111_1111;
        @(negedge clk);
        n_checks++; if (core_resp_rdata_o !== 32'h1111_1111 || core_resp_pma_err_o !== 1'b0) begin n_fail++; $display("FAIL erro_resp1: got %h/%b want 11111111/0", core_resp_rdata_o, core_resp_pma_err_o); end
        n_checks++; if (core_trans_ready_o !== 1'b0 || bus_trans_valid_o !== 1'b0) begin n_fail++; $display("FAIL erro_wait_block: got %b/%b want 0/0", core_trans_ready_o, bus_trans_valid_o); end
        next_cycle();
        bus_resp_rdata_i = 32'h2222_2222;
        bus_resp_err_i   = 1'b1;
        @(negedge clk);
        n_checks++; if (core_resp_rdata_o !== 32'h2222_2222 || core_resp_err_o !== 1'b1 || core_resp_pma_err_o !== 1'b0) begin n_fail++; $display("FAIL erro_resp2: got %h/%b/%b want 22222222/1/0", core_resp_rdata_o, core_resp_err_o, core_resp_pma_err_o); end
        next_cycle();
        bus_resp_valid_i = 1'b0;
        bus_resp_err_i   = 1'b0;
        @(negedge clk);
        n_checks++; if (core_resp_valid_o !== 1'b1 || core_resp_pma_err_o !== 1'b1 || core_resp_err_o !== 1'b0) begin n_fail++; $display("FAIL erro_pma_resp: got v%b p%b e%b want 1/1/0", core_resp_valid_o, core_resp_pma_err_o, core_resp_err_o); end
        n_checks++; if (core_trans_ready_o !== 1'b0) begin n_fail++; $display("FAIL erro_resp_ready: got %b want 0", core_trans_ready_o); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (bus_trans_valid_o !== 1'b1 || bus_trans_addr_o !== 32'h4000) begin n_fail++; $display("FAIL erro_resume: got %b/%h want 1/00004000", bus_trans_valid_o, bus_trans_addr_o); end
        next_cycle();
        idle_in();
        bus_resp_valid_i = 1'b1;
        next_cycle();
        idle_in();
        $display("test_err_after_outstanding done");
    endtask

    task automatic test_backpressure();
        load(32'h5000); next_cycle();
        load(32'h5004); next_cycle();
        load(32'h5008);
        @(negedge clk);
        n_checks++; if (core_trans_ready_o !== 1'b0 || bus_trans_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_full: got %b/%b want 0/0", core_trans_ready_o, bus_trans_valid_o); end
        next_cycle();
        bus_resp_valid_i = 1'b1;
        @(negedge clk);
        n_checks++; if (core_trans_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_resp: got %b want 0", core_trans_ready_o); end
        next_cycle();
        @(negedge clk);
        n_checks++; if (core_trans_ready_o !== 1'b1 || bus_trans_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_issue_resp: got %b/%b want 1/1", core_trans_ready_o, bus_trans_valid_o); end
        next_cycle();
        load(32'h500C);
        @(negedge clk);
        n_checks++; if (core_trans_ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_refill: got %b want 1", core_trans_ready_o); end
        next_cycle();
        load(32'h5010);
        @(negedge clk);
        n_checks++; if (core_trans_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_full_again: got %b want 0", core_trans_ready_o); end
        next_cycle();
        bus_resp_valid_i = 1'b1;
        next_cycle();
        bus_resp_valid_i = 1'b0;
        next_cycle();
        idle_in(); bus_resp_valid_i = 1'b1; next_cycle();
        idle_in(); bus_resp_valid_i = 1'b1; next_cycle();
        idle_in();
        $display("test_backpressure done");
    endtask

    task automatic test_reset_err_wait();
        load(32'h6000); next_cycle();
        load(32'h7000);
        pma_err_i = 1'b1;
        @(negedge clk);
        n_checks++; if (core_trans_ready_o !== 1'b1) begin n_fail++; $display("FAIL rew_err_accept: got %b want 1", core_trans_ready_o); end
        next_cycle();
        idle_in();
        bus_trans_ready_i = 1'b1;
        @(negedge clk);
        n_checks++; if (core_resp_valid_o !== 1'b0 || core_trans_ready_o !== 1'b0) begin n_fail++; $display("FAIL rew_waiting: got %b/%b want 0/0", core_resp_valid_o, core_trans_ready_o); end
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (core_resp_valid_o !== 1'b0 || core_trans_ready_o !== 1'b1) begin n_fail++; $display("FAIL rew_after_reset[%0d]: got resp %b ready %b want 0/1", i, core_resp_valid_o, core_trans_ready_o); end
            next_cycle();
        end
        load(32'h6100); next_cycle();
        load(32'h6104);
        @(negedge clk);
        n_checks++; if (core_trans_ready_o !== 1'b1) begin n_fail++; $display("FAIL rew_cnt_cleared: got %b want 1", core_trans_ready_o); end
        next_cycle();
        idle_in(); bus_resp_valid_i = 1'b1; next_cycle();
        idle_in(); bus_resp_valid_i = 1'b1; next_cycle();
        idle_in();
        $display("test_reset_err_wait done");
    endtask

    task automatic test_stray_resp();
        idle_in();
        bus_resp_valid_i = 1'b1;
        bus_resp_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        n_checks++; if (core_resp_valid_o !== 1'b1 || core_resp_rdata_o !== 32'hCAFE_F00D || core_resp_pma_err_o !== 1'b0) begin n_fail++; $display("FAIL stray_pass: got %b/%h/%b want 1/cafef00d/0", core_resp_valid_o, core_resp_rdata_o, core_resp_pma_err_o); end
        next_cycle();
        load(32'h8000);
        @(negedge clk);
        n_checks++; if (core_trans_ready_o !== 1'b1) begin n_fail++; $display("FAIL stray_ld1: got %b want 1", core_trans_ready_o); end
        next_cycle();
        load(32'h8004);
        @(negedge clk);
        n_checks++; if (core_trans_ready_o !== 1'b1) begin n_fail++; $display("FAIL stray_ld2: got %b want 1", core_trans_ready_o); end
        next_cycle();
        idle_in(); bus_resp_valid_i = 1'b1; next_cycle();
        idle_in(); bus_resp_valid_i = 1'b1; next_cycle();
        idle_in();
        $display("test_stray_resp done");
    endtask

    // Model: queue of owed responses in order; 0 = bus transaction, 1 = PMA error.
    task automatic test_random();
        int          order_q[$];
        bit          req_active = 1'b0;
        logic [31:0] r_addr = 32'h0;
        logic        r_we = 1'b0, r_instr = 1'b0, r_mis = 1'b0, r_perr = 1'b0, r_c = 1'b0, r_b = 1'b0;
        int          nbus;
        bit          has_err, err_due, resp;
        logic        exp_ready, exp_bval;
        int          n_acc = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (!req_active && cyc < 1450 && $urandom_range(0, 3) != 0) begin
                req_active = 1'b1;
                r_addr  = $urandom;
                r_we    = ($urandom_range(0, 1) == 1);
                r_instr = !r_we && ($urandom_range(0, 1) == 1);
                r_mis   = ($urandom_range(0, 7) == 0);
                r_perr  = ($urandom_range(0, 3) == 0);
                r_c     = ($urandom_range(0, 1) == 1);
                r_b     = ($urandom_range(0, 1) == 1);
            end
            nbus = 0; has_err = 1'b0;
            foreach (order_q[k]) begin
                if (order_q[k] == 0) nbus++;
                else has_err = 1'b1;
            end
            err_due = (order_q.size() > 0) && (order_q[0] == 1);
            resp    = (nbus > 0) && ($urandom_range(0, 1) == 1);
            core_trans_valid_i      = req_active;
            core_trans_addr_i       = r_addr;
            core_trans_we_i         = r_we;
            core_trans_instr_i      = r_instr;
            core_trans_misaligned_i = r_mis;
            pma_err_i               = r_perr;
            pma_cacheable_i         = r_c;
            pma_bufferable_i        = r_b;
            bus_trans_ready_i       = ($urandom_range(0, 9) < 7);
            bus_resp_valid_i        = resp;
            bus_resp_rdata_i        = resp ? $urandom : 32'h0;
            bus_resp_err_i          = resp && ($urandom_range(0, 9) == 0);
            if (has_err) begin
                exp_ready = 1'b0; exp_bval = 1'b0;
            end else if (req_active && r_perr) begin
                exp_ready = 1'b1; exp_bval = 1'b0;
            end else begin
                exp_bval  = req_active && (nbus < MAX);
                exp_ready = bus_trans_ready_i && (nbus < MAX);
            end
            @(negedge clk);
            n_checks++; if (bus_trans_valid_o !== exp_bval) begin n_fail++; $display("FAIL rnd_bus_valid cyc %0d: got %b want %b", cyc, bus_trans_valid_o, exp_bval); end
            n_checks++; if (core_trans_ready_o !== exp_ready) begin n_fail++; $display("FAIL rnd_ready cyc %0d: got %b want %b", cyc, core_trans_ready_o, exp_ready); end
            n_checks++; if (core_resp_valid_o !== (err_due || resp)) begin n_fail++; $display("FAIL rnd_resp_valid cyc %0d: got %b want %b", cyc, core_resp_valid_o, err_due || resp); end
            n_checks++; if (core_resp_pma_err_o !== err_due) begin n_fail++; $display("FAIL rnd_pma_err cyc %0d: got %b want %b", cyc, core_resp_pma_err_o, err_due); end
            if (req_active) begin
                n_checks++; if (pma_load_o !== (!r_we && !r_instr) || pma_misaligned_o !== r_mis) begin n_fail++; $display("FAIL rnd_pma_attr cyc %0d: got load %b mis %b want %b %b", cyc, pma_load_o, pma_misaligned_o, !r_we && !r_instr, r_mis); end
            end
            if (err_due || resp) begin
                n_checks++;
                if (core_resp_rdata_o !== (err_due ? 32'h0 : bus_resp_rdata_i) || core_resp_err_o !== (!err_due && bus_resp_err_i)) begin
                    n_fail++; $display("FAIL rnd_resp_data cyc %0d: got %h/%b want %h/%b", cyc, core_resp_rdata_o, core_resp_err_o, err_due ? 32'h0 : bus_resp_rdata_i, !err_due && bus_resp_err_i);
                end
            end
            if (exp_bval) begin
                n_checks++;
                if (bus_trans_addr_o !== r_addr || bus_trans_we_o !== r_we || bus_trans_memtype_o !== {r_c, r_b}) begin
                    n_fail++; $display("FAIL rnd_bus_attr cyc %0d: got %h/%b/%b want %h/%b/%b", cyc, bus_trans_addr_o, bus_trans_we_o, bus_trans_memtype_o, r_addr, r_we, {r_c, r_b});
                end
            end
            if (resp) void'(order_q.pop_front());
            if (err_due) void'(order_q.pop_front());
            if (req_active && exp_ready) begin
                order_q.push_back(r_perr ? 1 : 0);
                req_active = 1'b0;
                n_acc++;
            end
            next_cycle();
        end
        idle_in();
        $display("test_random done: %0d requests accepted", n_acc);
    endtask

    initial begin
        idle_in();
        rst_n = 1'b0;
        test_reset();
        test_pass_load();
        test_err_fetch();
        test_err_after_outstanding();
        test_backpressure();
        test_reset_err_wait();
        test_stray_resp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
